float_addsub_pipe: RTL and testbench

- Fully pipelined IEEE-754-style floating-point adder/subtractor; exponent and mantissa widths are parametrised.
- Accepts one operation per clock.
- Returns the result with a fixed latency of 3 cycles, together with a caller-supplied tag.
- Sits beside the float multiplier as an ALU/FPU functional unit; the dispatch stage uses the tag to route results to the destination register.

---
 rtl/float_pkg.sv | 27 ++
 rtl/float_addsub_pipe_if.sv | 20 ++
 rtl/float_lzc.sv | 23 ++
 rtl/float_addsub_pipe.sv | 229 ++++++++++++++++++++++
 tb/tb_float_addsub_pipe.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/float_pkg.sv
// Shared widths, canonical special encodings and operand shapes for the float functional units.
package float_pkg;

    localparam int FLOAT_EXP_WIDTH  = 8;
    localparam int FLOAT_MANT_WIDTH = 23;
    localparam int FLOAT_WIDTH      = 1 + FLOAT_EXP_WIDTH + FLOAT_MANT_WIDTH;

    localparam logic [FLOAT_WIDTH-1:0] FLOAT_QNAN =
        {1'b0, {FLOAT_EXP_WIDTH{1'b1}}, 1'b1, {(FLOAT_MANT_WIDTH-1){1'b0}}};
    localparam logic [FLOAT_WIDTH-1:0] FLOAT_POS_INF =
        {1'b0, {FLOAT_EXP_WIDTH{1'b1}}, {FLOAT_MANT_WIDTH{1'b0}}};
    localparam logic [FLOAT_WIDTH-1:0] FLOAT_NEG_INF =
        {1'b1, {FLOAT_EXP_WIDTH{1'b1}}, {FLOAT_MANT_WIDTH{1'b0}}};

    typedef struct packed {
        logic                        sign;
        logic [FLOAT_EXP_WIDTH-1:0]  exp;
        logic [FLOAT_MANT_WIDTH-1:0] mant;
    } float_t;

    typedef enum logic [1:0] {
        SPECIAL_NONE,
        SPECIAL_NAN,
        SPECIAL_INF
    } special_e;

endpackage

// File: rtl/float_addsub_pipe_if.sv
// Issue/result bundle of the pipelined float adder/subtractor.
interface float_addsub_pipe_if #(
    parameter int float_exp_width  = float_pkg::FLOAT_EXP_WIDTH,
    parameter int float_mant_width = float_pkg::FLOAT_MANT_WIDTH,
    parameter int tag_width        = 5
);
    localparam int FLOAT_W = 1 + float_exp_width + float_mant_width;

    logic                 req;
    logic                 sub;
    logic [FLOAT_W-1:0]   a;
    logic [FLOAT_W-1:0]   b;
    logic [tag_width-1:0] tag_in;
    logic [FLOAT_W-1:0]   out;
    logic                 ack;
    logic [tag_width-1:0] tag_out;

    modport master (output req, sub, a, b, tag_in, input out, ack, tag_out);
    modport slave  (input req, sub, a, b, tag_in, output out, ack, tag_out);
endinterface

// File: rtl/float_lzc.sv
// Leading-zero counter for the normalise stage; an all-zero input is flagged on 'zero'.
module float_lzc
    import float_pkg::*;
#(
    parameter int  WIDTH = FLOAT_MANT_WIDTH + 4,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count,
    output logic             zero
);

    // Scanning upwards lets the highest set bit win the final assignment.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) count = CW'(WIDTH - 1 - i);
        end
    end

    assign zero = ~|value;

endmodule

// File: rtl/float_addsub_pipe.sv
// Three-stage float add/sub (align, add, normalise) behind an input register; fixed latency 3.
// Define FLOAT_ADDSUB_ROUND_EN for guard/round/sticky and round-to-nearest-even instead of truncation.
module float_addsub_pipe
    import float_pkg::*;
#(
    parameter int float_exp_width  = FLOAT_EXP_WIDTH,
    parameter int float_mant_width = FLOAT_MANT_WIDTH,
    parameter int tag_width        = 5
) (
    input logic                clk,
    input logic                rst,
    float_addsub_pipe_if.slave bus
);

    localparam int E  = float_exp_width;
    localparam int M  = float_mant_width;
    localparam int W  = 1 + E + M;
`ifdef FLOAT_ADDSUB_ROUND_EN
    localparam int NG = 3;
`else
    localparam int NG = 2;
`endif
    localparam int MW = M + 2 + NG;
    localparam int CW = $clog2(MW);
    localparam int XW = E + 2;

    localparam logic [E-1:0]  EXP_MAX   = {E{1'b1}};
    localparam logic [E-1:0]  FAR_SHIFT = E'(M + 3);
    localparam logic [W-1:0]  QNAN      = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    logic                 s0_valid;
    logic [W-1:0]         s0_a, s0_b;
    logic [tag_width-1:0] s0_tag;

    // b's sign is flipped here so later stages only ever see an addition of signed operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_tag   <= '0;
        end else begin
            s0_valid <= bus.req;
            if (bus.req) begin
                s0_a   <= bus.a;
                s0_b   <= {bus.b[W-1] ^ bus.sub, bus.b[W-2:0]};
                s0_tag <= bus.tag_in;
            end
        end
    end

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] ma, mb, ma_f, mb_f;
    logic         a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_ge_b;

    assign {sa, ea, ma} = s0_a;
    assign {sb, eb, mb} = s0_b;
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign ma_f   = a_zero ? '0 : ma;
    assign mb_f   = b_zero ? '0 : mb;
    assign a_ge_b = {ea, ma_f} >= {eb, mb_f};

    logic          big_sign;
    logic [E-1:0]  big_exp, small_exp, exp_diff;
    logic [MW-1:0] big_vec, small_vec, shifted, aligned;
    special_e      special;
    logic          out_sign;

    // Swap so the larger magnitude is always the minuend, then align the smaller one to it.
    always_comb begin
        if (a_ge_b) begin
            big_sign  = sa;
            big_exp   = ea;
            big_vec   = {1'b0, ~a_zero, ma_f, {NG{1'b0}}};
            small_exp = eb;
            small_vec = {1'b0, ~b_zero, mb_f, {NG{1'b0}}};
        end else begin
            big_sign  = sb;
            big_exp   = eb;
            big_vec   = {1'b0, ~b_zero, mb_f, {NG{1'b0}}};
            small_exp = ea;
            small_vec = {1'b0, ~a_zero, ma_f, {NG{1'b0}}};
        end
        exp_diff = big_exp - small_exp;
        shifted  = small_vec >> exp_diff;
        aligned  = (exp_diff >= FAR_SHIFT) ? '0 : shifted;
`ifdef FLOAT_ADDSUB_ROUND_EN
        if (exp_diff >= FAR_SHIFT) aligned[0] = (small_vec != '0);
        else                       aligned[0] = shifted[0] | ((shifted << exp_diff) != small_vec);
`endif
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) special = SPECIAL_NAN;
        else if (a_inf || b_inf)                              special = SPECIAL_INF;
        else                                                  special = SPECIAL_NONE;
        out_sign = (special == SPECIAL_INF) ? (a_inf ? sa : sb) : big_sign;
    end

    logic                 s1_valid, s1_sign, s1_subtract;
    logic [E-1:0]         s1_exp;
    logic [MW-1:0]        s1_big, s1_small;
    special_e             s1_special;
    logic [tag_width-1:0] s1_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_subtract <= 1'b0;
            s1_exp      <= '0;
            s1_big      <= '0;
            s1_small    <= '0;
            s1_special  <= SPECIAL_NONE;
            s1_tag      <= '0;
        end else begin
            s1_valid    <= s0_valid;
            s1_sign     <= out_sign;
            s1_subtract <= (sa != sb);
            s1_exp      <= big_exp;
            s1_big      <= big_vec;
            s1_small    <= aligned;
            s1_special  <= special;
            s1_tag      <= s0_tag;
        end
    end

    logic                 s2_valid, s2_sign;
    logic [E-1:0]         s2_exp;
    logic [MW-1:0]        s2_sum;
    special_e             s2_special;
    logic [tag_width-1:0] s2_tag;

    // The swap guarantees big >= small, so the subtraction never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            s2_sign    <= 1'b0;
            s2_exp     <= '0;
            s2_sum     <= '0;
            s2_special <= SPECIAL_NONE;
            s2_tag     <= '0;
        end else begin
            s2_valid   <= s1_valid;
            s2_sign    <= s1_sign;
            s2_exp     <= s1_exp;
            s2_sum     <= s1_subtract ? (s1_big - s1_small) : (s1_big + s1_small);
            s2_special <= s1_special;
            s2_tag     <= s1_tag;
        end
    end

    logic [CW-1:0] lz;
    logic          lz_zero, carry, mant_zero;

    // Counting on the sum shifted up by one gives the shift that lands the leading one on the hidden bit.
    float_lzc #(.WIDTH(MW)) u_lzc (
        .value ({s2_sum[MW-2:0], 1'b0}),
        .count (lz),
        .zero  (lz_zero)
    );

    assign carry     = s2_sum[MW-1];
    assign mant_zero = ~carry & lz_zero;

    logic [MW-1:0] norm;
    logic [XW-1:0] exp_n, exp_f;
    logic [M-1:0]  mant_f;
    logic [W-1:0]  result;
    logic          unused_bits;
`ifdef FLOAT_ADDSUB_ROUND_EN
    logic          round_up;
    logic [M+1:0]  rmant;
`endif

    // Exponents are held XW bits wide so an underflow shows up as a set top bit.
    always_comb begin
        if (carry) begin
            norm  = s2_sum >> 1;
            exp_n = {2'b00, s2_exp} + XW'(1);
        end else begin
            norm  = s2_sum << lz;
            exp_n = {2'b00, s2_exp} - XW'(lz);
        end
`ifdef FLOAT_ADDSUB_ROUND_EN
        norm[0]  = norm[0] | s2_sum[0];
        round_up = norm[NG-1] & (norm[NG-2] | norm[NG-3] | norm[NG]);
        rmant    = {1'b0, norm[MW-2:NG]} + {{(M+1){1'b0}}, round_up};
        if (rmant[M+1]) begin
            exp_f  = exp_n + XW'(1);
            mant_f = '0;
        end else begin
            exp_f  = exp_n;
            mant_f = rmant[M-1:0];
        end
`else
        exp_f  = exp_n;
        mant_f = norm[MW-3:NG];
`endif
        if (s2_special == SPECIAL_NAN)                           result = QNAN;
        else if (s2_special == SPECIAL_INF)                      result = {s2_sign, EXP_MAX, {M{1'b0}}};
        else if (mant_zero)                                      result = '0;
        else if (exp_n[XW-1] || (exp_n == '0))                   result = {s2_sign, {(W-1){1'b0}}};
        else if (exp_f[XW-2:0] >= {1'b0, EXP_MAX})               result = {s2_sign, EXP_MAX, {M{1'b0}}};
        else                                                     result = {s2_sign, exp_f[E-1:0], mant_f};
    end

`ifdef FLOAT_ADDSUB_ROUND_EN
    assign unused_bits = ^{norm[MW-1], rmant[M]};
`else
    assign unused_bits = ^{norm[MW-1:MW-2], norm[NG-1:0]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack     <= 1'b0;
            bus.out     <= '0;
            bus.tag_out <= '0;
        end else begin
            bus.ack     <= s2_valid;
            bus.out     <= s2_valid ? result : '0;
            bus.tag_out <= s2_valid ? s2_tag : '0;
        end
    end

endmodule

// File: tb/tb_float_addsub_pipe.sv
// Directed-vector bench for float_addsub_pipe: a back-to-back stream of table vectors,
// then an asynchronous reset with ops in flight and a fresh op afterwards.
module tb_float_addsub_pipe;
    import float_pkg::*;

    localparam int TW = 5;
    localparam int NV = 20;

    typedef struct {
        logic [31:0]   a;
        logic [31:0]   b;
        logic          sub;
        logic [TW-1:0] tag;
        logic [31:0]   result;
    } vec_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    vec_t vecs [NV];

    float_addsub_pipe_if #(
        .float_exp_width  (FLOAT_EXP_WIDTH),
        .float_mant_width (FLOAT_MANT_WIDTH),
        .tag_width        (TW)
    ) bus ();

    float_addsub_pipe #(
        .float_exp_width  (FLOAT_EXP_WIDTH),
        .float_mant_width (FLOAT_MANT_WIDTH),
        .tag_width        (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic s, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [TW-1:0] t);
        bus.req    = r;
        bus.sub    = s;
        bus.a      = av;
        bus.b      = bv;
        bus.tag_in = t;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %08h, required %08h", name, actual, required);
        end
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_ack"}, {31'b0, bus.ack}, 32'h0);
        checkOutput({name, "_out"}, bus.out, 32'h0);
        checkOutput({name, "_tag"}, {27'b0, bus.tag_out}, 32'h0);
    endtask

    task automatic checkResult(input string name, input logic [31:0] value, input logic [TW-1:0] tag);
        checkOutput({name, "_ack"}, {31'b0, bus.ack}, 32'h1);
        checkOutput({name, "_out"}, bus.out, value);
        checkOutput({name, "_tag"}, {27'b0, bus.tag_out}, {27'b0, tag});
    endtask

    initial begin
        float_t inf_pos;
        compared   = 0;
        mismatched = 0;
        inf_pos    = '{sign: 1'b0, exp: 8'hff, mant: 23'h0};

        vecs[0]  = '{32'h3f800000, 32'h40000000, 1'b0, 5'd3,  32'h40400000};
        vecs[1]  = '{32'h40a00000, 32'h40400000, 1'b1, 5'd0,  32'h40000000};
        vecs[2]  = '{32'h3fc00000, 32'h3fc00000, 1'b1, 5'd1,  32'h00000000};
        vecs[3]  = '{32'h7f7fffff, 32'h7f7fffff, 1'b0, 5'd2,  32'h7f800000};
        vecs[4]  = '{32'h7f800000, 32'h7f800000, 1'b1, 5'd4,  FLOAT_QNAN};
        vecs[5]  = '{32'h7fc00001, 32'h3f800000, 1'b0, 5'd5,  32'h7fc00000};
        vecs[6]  = '{32'h3f800001, 32'hbf800000, 1'b0, 5'd6,  32'h34000000};
        vecs[7]  = '{32'h3f800000, 32'h33000000, 1'b0, 5'd7,  32'h3f800000};
        vecs[8]  = '{32'hbf800000, 32'h3f000000, 1'b0, 5'd8,  32'hbf000000};
        vecs[9]  = '{32'h00000000, 32'h00000000, 1'b1, 5'd9,  32'h00000000};
        vecs[10] = '{32'h00000001, 32'h3f800000, 1'b0, 5'd10, 32'h3f800000};
        vecs[11] = '{32'h80800001, 32'h00800000, 1'b0, 5'd11, 32'h80000000};
        vecs[12] = '{inf_pos,      32'h3f800000, 1'b0, 5'd12, FLOAT_POS_INF};
        vecs[13] = '{32'h3f800000, 32'h7f800000, 1'b1, 5'd13, FLOAT_NEG_INF};
        vecs[14] = '{32'h80000000, 32'h80000000, 1'b0, 5'd14, 32'h00000000};
        vecs[15] = '{32'h3fc00000, 32'h3fc00000, 1'b0, 5'd15, 32'h40400000};
        vecs[16] = '{32'h7f000000, 32'h7f000000, 1'b0, 5'd16, 32'h7f800000};
        vecs[17] = '{32'h3f800001, 32'h33800000, 1'b0, 5'd17, 32'h3f800001};
        vecs[18] = '{32'h4f000000, 32'h3f800000, 1'b0, 5'd18, 32'h4f000000};
        vecs[19] = '{32'h3f800000, 32'h40000000, 1'b1, 5'd31, 32'hbf800000};

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        // Issue every vector on consecutive edges; each result is due 3 edges after its issue.
        for (int c = 0; c < NV + 4; c++) begin
            if (c < NV) applyStimulus(1'b1, vecs[c].sub, vecs[c].a, vecs[c].b, vecs[c].tag);
            else        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, '0);
            @(posedge clk);
            @(negedge clk);
            if (c >= 3 && c - 3 < NV) checkResult($sformatf("vec%0d", c - 3), vecs[c-3].result, vecs[c-3].tag);
            else                      checkIdle($sformatf("stream_idle%0d", c));
        end

        // Three ops back to back; reset lands while the first is acked and two are in flight.
        applyStimulus(1'b1, 1'b0, 32'h3f800000, 32'h40000000, 5'd10);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h40a00000, 32'h40400000, 5'd11);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h3fc00000, 32'h3fc00000, 5'd12);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, '0);
        @(posedge clk);
        @(negedge clk);
        checkResult("pre_reset", 32'h40400000, 5'd10);
        #2 rst = 1'b1;
        #1 checkIdle("async_reset");
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkIdle($sformatf("in_reset%0d", k));
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkIdle("post_reset_idle");

        for (int k = 0; k < 5; k++) begin
            if (k == 0) applyStimulus(1'b1, 1'b1, 32'h40a00000, 32'h40400000, 5'd21);
            else        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, '0);
            @(posedge clk);
            @(negedge clk);
            if (k == 3) checkResult("after_reset", 32'h40000000, 5'd21);
            else        checkIdle($sformatf("after_reset_idle%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
